// File: rtl/force_port_ctrl_if.sv
// force_port_ctrl_if: port data and command/status bundle for force_port_ctrl.
// master = debug command source and port source/consumer side, slave = the controller.
interface force_port_ctrl_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DUR_W = 8,
  parameter int unsigned CH_W  = 4
);
  logic [NCH*WIDTH-1:0] i_data;
  logic [NCH*WIDTH-1:0] o_data;
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic [1:0]           i_cmd_op;
  logic [CH_W-1:0]      i_cmd_ch;
  logic [WIDTH-1:0]     i_cmd_mask;
  logic [WIDTH-1:0]     i_cmd_value;
  logic [DUR_W-1:0]     i_cmd_dur;
  logic                 o_ack;
  logic                 o_ack_err;
  logic [NCH-1:0]       o_forced;
  logic [NCH-1:0]       o_expire;

  modport master (
    output i_data, i_cmd_valid, i_cmd_op, i_cmd_ch, i_cmd_mask, i_cmd_value, i_cmd_dur,
    input  o_data, o_cmd_ready, o_ack, o_ack_err, o_forced, o_expire
  );

  modport slave (
    input  i_data, i_cmd_valid, i_cmd_op, i_cmd_ch, i_cmd_mask, i_cmd_value, i_cmd_dur,
    output o_data, o_cmd_ready, o_ack, o_ack_err, o_forced, o_expire
  );
endinterface

// File: rtl/force_port_ctrl.sv
// force_port_ctrl: runtime per-bit force/release of NCH channels of WIDTH bits, with a
// command handshake (1 command per 2 cycles), timed auto-release and expiry reporting.
// Optional: define FORCE_PORT_OUT_REG_EN to register o_data (1-cycle latency, reset 0),
// which keeps o_data aligned with the registered o_forced.
module force_port_ctrl #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DUR_W = 8,
  parameter int unsigned CH_W  = 4  // must satisfy 2**CH_W >= NCH
) (
  input logic              i_clk,
  input logic              i_arst_n,
  force_port_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StApply} state_e;

  localparam logic [1:0] OpNop        = 2'b00;
  localparam logic [1:0] OpForce      = 2'b01;
  localparam logic [1:0] OpRelease    = 2'b10;
  localparam logic [1:0] OpReleaseAll = 2'b11;

  state_e                    state_q, state_d;
  logic                      accept, apply, ack, ack_err, ready;
  logic [1:0]                op_q;
  logic [CH_W-1:0]           ch_q;
  logic [WIDTH-1:0]          cmask_q, cval_q;
  logic [DUR_W-1:0]          dur_q;
  logic [31:0]               ch_idx;
  logic                      ch_oor;
  logic [NCH-1:0][WIDTH-1:0] fmask_q, fmask_d, fval_q, fval_d;
  logic [NCH-1:0][DUR_W-1:0] timer_q, timer_d;
  logic [NCH-1:0]            expire_q, expire_d, forced_q, mask_any;
  logic [NCH*WIDTH-1:0]      mask_flat, val_flat, mux_data;

  assign ch_idx = 32'(ch_q);
  assign ch_oor = ch_idx >= NCH;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // FSM next state and handshake/ack outputs
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    apply   = 1'b0;
    ready   = 1'b0;
    ack     = 1'b0;
    ack_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (bus.i_cmd_valid) begin
          accept  = 1'b1;
          state_d = StApply;
        end
      end
      StApply: begin
        apply   = 1'b1;
        ack     = 1'b1;
        // RELEASE_ALL ignores the channel field, so it can never be out of range
        ack_err = ch_oor && (op_q == OpForce || op_q == OpRelease);
        state_d = StIdle;
      end
    endcase
  end

  // Command capture in IDLE
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      op_q    <= OpNop;
      ch_q    <= '0;
      cmask_q <= '0;
      cval_q  <= '0;
      dur_q   <= '0;
    end else if (accept) begin
      op_q    <= bus.i_cmd_op;
      ch_q    <= bus.i_cmd_ch;
      cmask_q <= bus.i_cmd_mask;
      cval_q  <= bus.i_cmd_value;
      dur_q   <= bus.i_cmd_dur;
    end
  end

  // Per-channel next state: timer expiry first, then the command being applied
  always_comb begin
    fmask_d  = fmask_q;
    fval_d   = fval_q;
    timer_d  = timer_q;
    expire_d = '0;
    mask_any = '0;
    for (int k = 0; k < NCH; k++) begin
      mask_any[k] = |fmask_q[k];
      if (timer_q[k] != '0) begin
        timer_d[k] = timer_q[k] - DUR_W'(1);
        if (timer_q[k] == DUR_W'(1)) begin
          fmask_d[k]  = '0;
          expire_d[k] = 1'b1;
        end
      end
      if (apply) begin
        unique case (op_q)
          OpNop: ;
          OpForce: begin
            if (ch_idx == 32'(k)) begin
              fmask_d[k] = fmask_d[k] | cmask_q;
              fval_d[k]  = (fval_q[k] & ~cmask_q) | (cval_q & cmask_q);
              timer_d[k] = dur_q;
            end
          end
          OpRelease: begin
            if (ch_idx == 32'(k)) begin
              fmask_d[k] = fmask_d[k] & ~cmask_q;
              if (fmask_d[k] == '0) timer_d[k] = '0;
            end
          end
          OpReleaseAll: begin
            fmask_d[k]  = '0;
            timer_d[k]  = '0;
            expire_d[k] = 1'b0;
          end
        endcase
      end
    end
  end

  // Force masks, values, timers and registered status
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      fmask_q  <= '0;
      fval_q   <= '0;
      timer_q  <= '0;
      expire_q <= '0;
      forced_q <= '0;
    end else begin
      fmask_q  <= fmask_d;
      fval_q   <= fval_d;
      timer_q  <= timer_d;
      expire_q <= expire_d;
      forced_q <= mask_any;
    end
  end

  assign mask_flat = fmask_q;
  assign val_flat  = fval_q;
  assign mux_data  = (bus.i_data & ~mask_flat) | (val_flat & mask_flat);

`ifdef FORCE_PORT_OUT_REG_EN
  logic [NCH*WIDTH-1:0] data_q;

  // Registered output data, one cycle behind the mux like o_forced
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) data_q <= '0;
    else           data_q <= mux_data;
  end

  assign bus.o_data = data_q;
`else
  assign bus.o_data = mux_data;
`endif

  assign bus.o_cmd_ready = ready;
  assign bus.o_ack       = ack;
  assign bus.o_ack_err   = ack_err;
  assign bus.o_forced    = forced_q;
  assign bus.o_expire    = expire_q;

endmodule

// File: tb/tb_force_port_ctrl.sv
// tb_force_port_ctrl: directed bench for force_port_ctrl (default build, combinational o_data).
`timescale 1ns/1ps
module tb_force_port_ctrl;
  localparam int unsigned NCH   = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DUR_W = 8;
  localparam int unsigned CH_W  = 4;

  localparam logic [1:0]  OP_NOP = 2'b00, OP_FORCE = 2'b01, OP_REL = 2'b10, OP_RELALL = 2'b11;
  localparam logic [31:0] IN_DATA = 32'h3C2A1B0F;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];  // expected o_ack_err per issued command

  force_port_ctrl_if #(.NCH(NCH), .WIDTH(WIDTH), .DUR_W(DUR_W), .CH_W(CH_W)) bus ();

  force_port_ctrl #(.NCH(NCH), .WIDTH(WIDTH), .DUR_W(DUR_W), .CH_W(CH_W)) dut (
    .i_clk   (clk),
    .i_arst_n(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called during an APPLY cycle: ack must be up and match the scoreboard head.
  task automatic ack_pop(input string tag);
    logic e;
    chk({tag, "_ack"}, bus.o_ack, 1'b1);
    chk({tag, "_sb_depth"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_ack_err"}, bus.o_ack_err, e);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Enter at posedge+1 in IDLE; returns at posedge+1 right after the APPLY edge.
  task automatic send_cmd(input string tag, input logic [1:0] op, input logic [3:0] ch,
                          input logic [7:0] mask, input logic [7:0] val, input logic [7:0] dur,
                          input logic exp_err);
    exp_q.push_back(exp_err);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = op;
    bus.i_cmd_ch    = ch;
    bus.i_cmd_mask  = mask;
    bus.i_cmd_value = val;
    bus.i_cmd_dur   = dur;
    @(negedge clk);
    chk({tag, "_ready"}, bus.o_cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.i_cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, bus.o_cmd_ready, 1'b0);
    ack_pop(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n55, nexp;
    logic [31:0] exp_d;
    logic [3:0]  exp_e;

    bus.i_data      = IN_DATA;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = OP_NOP;
    bus.i_cmd_ch    = '0;
    bus.i_cmd_mask  = '0;
    bus.i_cmd_value = '0;
    bus.i_cmd_dur   = '0;
    rst_n           = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_data", bus.o_data, IN_DATA);
    chk("rst_forced", bus.o_forced, 4'b0000);
    chk("rst_ready", bus.o_cmd_ready, 1'b1);
    chk("rst_ack", bus.o_ack, 1'b0);
    chk("rst_expire", bus.o_expire, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    to_drive();
    chk("idle_data", bus.o_data, IN_DATA);

    // Permanent partial force on ch1
    send_cmd("f1", OP_FORCE, 4'd1, 8'hF0, 8'hA5, 8'd0, 1'b0);
    chk("f1_data", bus.o_data, 32'h3C2AAB0F);
    to_drive();
    chk("f1_forced", bus.o_forced, 4'b0010);
    bus.i_data = 32'h3C2A000F;
    #1 chk("f1_mux", bus.o_data, 32'h3C2AA00F);
    bus.i_data = IN_DATA;
    repeat (1000) @(posedge clk);
    #1;
    chk("f1_hold_data", bus.o_data, 32'h3C2AAB0F);
    chk("f1_hold_forced", bus.o_forced, 4'b0010);

    // Timed force ch2, dur=5
    send_cmd("f2", OP_FORCE, 4'd2, 8'hFF, 8'h55, 8'd5, 1'b0);
    n55 = 0;
    nexp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_data[23:16] == 8'h55) n55++;
      if (bus.o_expire[2]) begin
        nexp++;
        chk("f2_exp_idx", i, 32'd5);
      end
    end
    chk("f2_cycles", n55, 32'd5);
    chk("f2_nexp", nexp, 32'd1);
    chk("f2_data", bus.o_data, 32'h3C2AAB0F);
    chk("f2_forced", bus.o_forced, 4'b0010);

    // Partial release keeps the timer
    to_drive();
    send_cmd("f0", OP_FORCE, 4'd0, 8'h0F, 8'h05, 8'd10, 1'b0);
    chk("f0_data", bus.o_data, 32'h3C2AAB05);
    send_cmd("r0p", OP_REL, 4'd0, 8'h03, 8'h00, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_d = (i < 8) ? 32'h3C2AAB07 : 32'h3C2AAB0F;
      exp_e = (i == 8) ? 4'b0001 : 4'b0000;
      chk("r0p_data", bus.o_data, exp_d);
      chk("r0p_expire", bus.o_expire, exp_e);
    end

    // Full release clears the timer, no expiry
    to_drive();
    send_cmd("f0b", OP_FORCE, 4'd0, 8'h0F, 8'h05, 8'd10, 1'b0);
    send_cmd("r0f", OP_REL, 4'd0, 8'h0F, 8'h00, 8'd0, 1'b0);
    nexp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.o_expire != 4'b0000) nexp++;
    end
    chk("r0f_nexp", nexp, 32'd0);
    chk("r0f_data", bus.o_data, 32'h3C2AAB0F);
    chk("r0f_forced", bus.o_forced, 4'b0010);

    // Out-of-range channel
    to_drive();
    send_cmd("oor", OP_FORCE, 4'd5, 8'hFF, 8'h00, 8'd0, 1'b1);
    chk("oor_data", bus.o_data, 32'h3C2AAB0F);
    to_drive();
    chk("oor_forced", bus.o_forced, 4'b0010);

    // Back-to-back valid: source holds valid across two commands
    exp_q.push_back(1'b0);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = OP_NOP;
    bus.i_cmd_ch    = 4'd0;
    @(negedge clk);
    chk("b2b_ready0", bus.o_cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    exp_q.push_back(1'b0);
    bus.i_cmd_op   = OP_REL;
    bus.i_cmd_ch   = 4'd3;
    bus.i_cmd_mask = 8'hFF;
    @(negedge clk);
    chk("b2b_ready1", bus.o_cmd_ready, 1'b0);
    ack_pop("b2b_a");
    @(negedge clk);
    chk("b2b_ready2", bus.o_cmd_ready, 1'b1);
    chk("b2b_gap_ack", bus.o_ack, 1'b0);
    @(posedge clk);
    #1 bus.i_cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_ready3", bus.o_cmd_ready, 1'b0);
    ack_pop("b2b_b");
    to_drive();
    chk("b2b_data", bus.o_data, 32'h3C2AAB0F);

    // Re-force on the expiry cycle
    send_cmd("f3", OP_FORCE, 4'd3, 8'hFF, 8'h77, 8'd3, 1'b0);
    chk("f3_data", bus.o_data, 32'h772AAB0F);
    to_drive();
    send_cmd("f3r", OP_FORCE, 4'd3, 8'hFF, 8'h99, 8'd4, 1'b0);
    chk("f3r_data", bus.o_data, 32'h992AAB0F);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_d = (i < 4) ? 32'h992AAB0F : 32'h3C2AAB0F;
      exp_e = (i == 0 || i == 4) ? 4'b1000 : 4'b0000;
      chk("f3r_data_t", bus.o_data, exp_d);
      chk("f3r_expire", bus.o_expire, exp_e);
    end

    // RELEASE_ALL on the expiry cycle suppresses o_expire
    to_drive();
    send_cmd("f2b", OP_FORCE, 4'd2, 8'hFF, 8'h55, 8'd3, 1'b0);
    to_drive();
    send_cmd("ra", OP_RELALL, 4'd15, 8'h00, 8'h00, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ra_expire", bus.o_expire, 4'b0000);
      chk("ra_data", bus.o_data, IN_DATA);
    end
    chk("ra_forced", bus.o_forced, 4'b0000);

    // Async reset mid-APPLY with a force active
    to_drive();
    send_cmd("f1b", OP_FORCE, 4'd1, 8'hF0, 8'hA5, 8'd0, 1'b0);
    to_drive();
    chk("f1b_forced", bus.o_forced, 4'b0010);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = OP_FORCE;
    bus.i_cmd_ch    = 4'd2;
    bus.i_cmd_mask  = 8'hFF;
    bus.i_cmd_value = 8'h55;
    bus.i_cmd_dur   = 8'd0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", bus.o_ack, 1'b0);
    chk("arst_data", bus.o_data, IN_DATA);
    chk("arst_forced", bus.o_forced, 4'b0000);
    bus.i_cmd_valid = 1'b0;
    to_drive();
    rst_n = 1'b1;
    to_drive();
    @(negedge clk);
    chk("post_ack", bus.o_ack, 1'b0);
    chk("post_data", bus.o_data, IN_DATA);
    chk("post_forced", bus.o_forced, 4'b0000);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/force_port_ctrl.md
Name: force_port_ctrl

Overview:
- Parametrised runtime force/release controller for multi-channel port buses. Generalises the per-bit force/release mux into NCH channels of WIDTH bits each.
- Adds a command handshake, per-bit force masks, timed auto-release and expiry/status reporting.
- Sits between a port source and its consumer; driven by the debug/emulation command path.

Parameters:
- NCH, 4, number of channels (1..16)
- WIDTH, 8, bits per channel
- DUR_W, 8, force-duration counter width
- CH_W, 4, channel index width; must satisfy 2**CH_W >= NCH

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_data  in  NCH*WIDTH  unforced port data; channel k occupies [k*WIDTH +: WIDTH]
- o_data  out  NCH*WIDTH  port data after force muxing
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_op  in  2  command opcode: 00 NOP, 01 FORCE, 10 RELEASE, 11 RELEASE_ALL
- i_cmd_ch  in  CH_W  target channel
- i_cmd_mask  in  WIDTH  bits affected by the command
- i_cmd_value  in  WIDTH  force value
- i_cmd_dur  in  DUR_W  force duration in cycles; 0 = permanent
- o_ack  out  1  one-cycle pulse when a command has been applied
- o_ack_err  out  1  qualifies o_ack: channel index out of range; command dropped
- o_forced  out  NCH  per-channel indicator: OR of that channel's force mask
- o_expire  out  NCH  one-cycle pulse per channel on timed auto-release

Behaviour:
- Reset (async assert, sync deassert by i_clk): all masks, values and timers = 0. FSM = IDLE. o_cmd_ready=1, o_ack=0, o_ack_err=0, o_forced=0, o_expire=0. o_data tracks i_data.
- Datapath, per bit: o_data = mask ? fval : i_data. Combinational unless FORCE_PORT_OUT_REG_EN is defined.
- FSM has two states, IDLE and APPLY:
  - IDLE: o_cmd_ready=1. On i_cmd_valid, latch op/ch/mask/value/dur and go to APPLY.
  - APPLY: o_cmd_ready=0. Update registers, pulse o_ack, return to IDLE.
  - Throughput is 1 command per 2 cycles.
  - A NOP is acked without any state change.
- FORCE on ch:
  - mask |= cmd_mask.
  - fval bits under cmd_mask = cmd_value; other fval bits are unchanged.
  - If cmd_dur != 0, timer = cmd_dur; if cmd_dur == 0, timer = 0 (permanent). A new FORCE always overwrites the timer.
- RELEASE on ch: mask &= ~cmd_mask. If the resulting mask == 0, timer = 0. A partial release keeps the timer running.
- RELEASE_ALL: every mask and every timer = 0. i_cmd_ch is ignored; never an error.
- Out-of-range channel: FORCE/RELEASE with ch >= NCH gives o_ack=1 and o_ack_err=1 with no state change.
- Timer:
  - While timer != 0, it decrements every cycle.
  - On the cycle it goes 1 -> 0, the channel mask is cleared and o_expire[ch] pulses one cycle later (registered).
  - A FORCE with dur=N therefore holds the bits for exactly N cycles after the APPLY cycle.
- Same-cycle expiry and APPLY on the same channel: expiry is evaluated first, then the command.
  - FORCE re-forces and reloads the timer; o_expire still pulses.
  - RELEASE_ALL in that cycle suppresses o_expire.
- o_forced is registered from the masks and updates the cycle after the change.
- i_cmd_valid without ready: the command is held by the source; the block samples it only in IDLE.
- Reset asserted mid-APPLY: the command is lost, no o_ack, all forces released immediately.

Optional Feature:
- FORCE_PORT_OUT_REG_EN defined:
  - o_data is registered (reset value 0).
  - Latency from i_data or a force change to o_data is 1 cycle.
  - o_forced stays aligned with o_data.
- Not defined: o_data is a combinational mux; zero latency from i_data.

Test Plan (NCH=4, WIDTH=8, DUR_W=8):
- Reset then i_data=0x3C2A1B0F: o_data=0x3C2A1B0F, o_forced=0, o_cmd_ready=1.
- FORCE ch1 mask=0xF0 value=0xA5 dur=0, i_data[15:8]=0x1B: o_ack pulses in APPLY; o_data[15:8]=0xAB; o_forced=0010 persists for 1000 cycles.
- FORCE ch2 mask=0xFF value=0x55 dur=5:
  - o_data[23:16]=0x55 for exactly 5 cycles, then 0x2A.
  - o_expire[2] pulses once; o_forced[2] returns to 0.
- FORCE ch0 mask=0x0F dur=10; RELEASE ch0 mask=0x03 at cycle 3: bits[3:2] stay forced until expiry at cycle 10. A full RELEASE mask=0x0F instead clears the timer with no o_expire.
- FORCE ch5: o_ack=1, o_ack_err=1, o_data and o_forced unchanged. Back-to-back valid: o_cmd_ready toggles 1/0, second command acked 2 cycles after the first.
- Timed force dur=3 on ch3, with FORCE ch3 dur=4 applied on the expiry cycle: o_expire[3] pulses, bits stay forced 4 more cycles. Async reset mid-force: o_data=i_data immediately, o_forced=0.
